demux_1x2_latch: RTL and testbench
==================================

Name: demux_1x2_latch

Overview:
- Reverse-direction counterpart of the datapath 2:1 select. Steers one 8-bit datapath value into one of two registered destination slots (e.g. instruction latch vs. memory-data latch) selected by `select`.
- Each slot has a valid/ack handshake toward its consumer stage of the multicycle controller. The producer sees a single ready signal.
- Sits between the memory/ALU result bus and the two downstream holding registers.

Parameters:
- WIDTH, 8, data width of input and both slots.
- CNT_WIDTH, 8, width of the per-slot accepted-transfer counters (wrap-around).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- inputValue  input  WIDTH  data to steer.
- select  input  1  0 -> slot 1, 1 -> slot 2.
- inValid  input  1  producer presents inputValue/select this cycle.
- inReady  output  1  selected slot can accept this cycle (combinational).
- outputValue1  output  WIDTH  slot 1 held data.
- outputValue2  output  WIDTH  slot 2 held data.
- valid1  output  1  slot 1 holds unconsumed data.
- valid2  output  1  slot 2 holds unconsumed data.
- ack1  input  1  consumer 1 takes slot 1 data this cycle.
- ack2  input  1  consumer 2 takes slot 2 data this cycle.
- count1  output  CNT_WIDTH  transfers accepted into slot 1.
- count2  output  CNT_WIDTH  transfers accepted into slot 2.

Behaviour:
- Reset (synchronous, active-high): all registered outputs cleared on the next clk edge while reset=1. This covers outputValue1/2 = 0, valid1/2 = 0 and count1/2 = 0. Reset overrides any simultaneous inValid/ack, including mid-transfer.
- Per-slot FSM has two states, EMPTY and FULL. The valid output equals (state == FULL).
- Slot n readiness: readyN = !validN | ackN, so a consume and a refill can happen in the same cycle.
- inReady = select ? ready2 : ready1. It is purely combinational from select, valid and ack. It does not depend on inValid.
- Accept condition: inValid & inReady.
  - On accept, the selected slot's outputValue takes inputValue and its count increments by 1. The count wraps from 2^CNT_WIDTH-1 to 0.
  - The slot enters (or stays) FULL.
  - The non-selected slot is untouched.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack without accept.
  - FULL -> FULL on ack with accept (data replaced, count +1).
  - FULL with no ack: stays FULL and holds data; a write to it is blocked (inReady = 0).
- Latency: data is visible on outputValueN and validN exactly one clk after accept.
- ack on an EMPTY slot is ignored (no state change, no underflow).
- The outputValue of an EMPTY slot keeps its last data. Consumers must qualify with valid.
- Both slots may be acked in the same cycle; they are independent.
- A blocked write (inValid=1, inReady=0) has no side effect. The producer must hold inputValue/select until accept.

Optional Feature:
- Macro: DEMUX_OVERWRITE_EN.
- Defined: a write to a FULL, un-acked slot is accepted (inReady = 1 always). The old data is overwritten and count increments. Sticky output `overrun` (1 bit, reset 0) is set and is cleared only by reset.
- Undefined: back-pressure behaviour as specified above. There is no overrun port.

Decomposition:
- Shared package holds:
  - the slot state encoding (EMPTY = 1'b0, FULL = 1'b1);
  - the default WIDTH = 8, matching the 8-bit datapath;
  - the CNT_WIDTH default.
- One natural sub-module, demux_slot: a single data register plus FSM plus counter with accept/ack. It is instantiated twice, and the top adds the select steering and inReady mux.

Test Plan:
- Reset: drive reset=1 for 2 cycles with inValid=1, ack1=1 -> outputValue1/2 = 0x00, valid1/2 = 0, count1/2 = 0, inReady = 1.
- Steering: write 0xA5 with select=0, then 0x3C with select=1 -> outputValue1 = 0xA5 and valid1 = 1 one cycle after the first write; outputValue2 = 0x3C and valid2 = 1 one cycle after the second; count1 = 1, count2 = 1.
- Back-pressure: slot 1 FULL with 0x11, no ack1, inValid=1, select=0, data 0x22 -> inReady = 0, outputValue1 stays 0x11, count1 unchanged; a simultaneous select=1 write still goes to slot 2.
- Same-cycle ack+write: slot 1 FULL with 0x11, ack1=1 and write 0x22 in the same cycle -> inReady = 1, next cycle outputValue1 = 0x22, valid1 = 1, count1 +1.
- Counter wrap: 256 accepts into slot 2 with ack2 held 1 -> count2 returns to 0x00; a spurious ack2 while EMPTY leaves valid2 = 0.
- With DEMUX_OVERWRITE_EN defined: slot 1 FULL 0x11, write 0x99 without ack -> outputValue1 = 0x99, overrun = 1 and stays 1 until reset.

Source files
------------

// File: rtl/demux_1x2_latch_pkg.sv
// ---------------------------------------------------------------------------
// demux_1x2_latch_pkg
// Shared definitions for the 1:2 registered demux and its slot sub-module.
//   slot_state_e      : per-slot FSM encoding (EMPTY = 0, FULL = 1)
//   DEFAULT_WIDTH     : datapath width (8-bit datapath)
//   DEFAULT_CNT_WIDTH : width of the per-slot accepted-transfer counters
// ---------------------------------------------------------------------------
package demux_1x2_latch_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One destination slot: data register, EMPTY/FULL FSM and a wrapping
// accepted-transfer counter.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   load   in   accept this cycle (steering + handshake already resolved)
//   data   in   WIDTH  value captured on load
//   ack    in   consumer takes the held value this cycle
//   value  out  WIDTH  held data (kept while EMPTY; qualify with state)
//   state  out  current FSM state (debug-visible; 1 = FULL)
//   count  out  CNT_WIDTH  accepted transfers, wraps to 0
//   ready  out  slot can take new data this cycle (!FULL | ack)
// ---------------------------------------------------------------------------
module demux_slot
  import demux_1x2_latch_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data,
  input  logic                 ack,
  output logic [WIDTH-1:0]     value,
  output logic                 state,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ready
);

  slot_state_e             state_q;
  logic [WIDTH-1:0]        value_q;
  logic [CNT_WIDTH-1:0]    count_q;

  // A consume and a refill may happen in the same cycle.
  assign ready = (state_q == SLOT_EMPTY) | ack;

  // Load wins over ack: an ack with a simultaneous load leaves the slot FULL
  // with the new data. An ack while EMPTY falls into the EMPTY assignment
  // and therefore has no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      value_q <= '0;
      count_q <= '0;
    end else if (load) begin
      state_q <= SLOT_FULL;
      value_q <= data;
      count_q <= count_q + CNT_WIDTH'(1);
    end else if (ack) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign value = value_q;
  assign state = state_q;
  assign count = count_q;

endmodule

// File: rtl/demux_1x2_latch.sv
// ---------------------------------------------------------------------------
// demux_1x2_latch
// Steers one datapath value into one of two registered holding slots
// (select = 0 -> slot 1, select = 1 -> slot 2). Each slot offers a
// valid/ack handshake to its consumer; the producer sees one ready.
//
// Handshake semantics: the producer asserts inValid with stable
// inputValue/select; a transfer happens on a rising edge where
// inValid & inReady. inReady is combinational from select and the selected
// slot's valid/ack and never depends on inValid. A slot's data is consumed
// on a rising edge where validN & ackN; ackN while EMPTY is ignored.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inputValue [WIDTH]          data to steer
//   select                      destination slot
//   inValid / inReady           producer handshake
//   outputValue1/2 [WIDTH]      held slot data (visible one clk after accept)
//   valid1/2, ack1/2            consumer handshakes
//   count1/2 [CNT_WIDTH]        accepted transfers per slot (wrap-around)
//   overrun                     only with DEMUX_OVERWRITE_EN: sticky flag set
//                               when a FULL, un-acked slot is overwritten
//
// Build option: DEMUX_OVERWRITE_EN -- writes are never back-pressured;
// overwriting un-consumed data sets the sticky overrun output.
// ---------------------------------------------------------------------------
module demux_1x2_latch
  import demux_1x2_latch_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     inputValue,
  input  logic                 select,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [WIDTH-1:0]     outputValue1,
  output logic [WIDTH-1:0]     outputValue2,
  output logic                 valid1,
  output logic                 valid2,
  input  logic                 ack1,
  input  logic                 ack2,
  output logic [CNT_WIDTH-1:0] count1,
  output logic [CNT_WIDTH-1:0] count2
`ifdef DEMUX_OVERWRITE_EN
  ,
  output logic                 overrun
`endif
);

  logic ready1, ready2;
  logic state1, state2;
  logic load1, load2;
  logic sel_ready;
  logic accept;

  // Back-pressure view of the selected slot, independent of the build option.
  assign sel_ready = select ? ready2 : ready1;

`ifdef DEMUX_OVERWRITE_EN
  assign inReady = 1'b1;
`else
  assign inReady = sel_ready;
`endif

  assign accept = inValid & inReady;
  assign load1  = accept & ~select;
  assign load2  = accept &  select;

  demux_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot1 (
    .clk   (clk),
    .reset (reset),
    .load  (load1),
    .data  (inputValue),
    .ack   (ack1),
    .value (outputValue1),
    .state (state1),
    .count (count1),
    .ready (ready1)
  );

  demux_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot2 (
    .clk   (clk),
    .reset (reset),
    .load  (load2),
    .data  (inputValue),
    .ack   (ack2),
    .value (outputValue2),
    .state (state2),
    .count (count2),
    .ready (ready2)
  );

  assign valid1 = (state1 == SLOT_FULL);
  assign valid2 = (state2 == SLOT_FULL);

`ifdef DEMUX_OVERWRITE_EN
  // An accepted write the back-pressure rule would have blocked means a
  // FULL slot lost un-consumed data.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (inValid & ~sel_ready) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x2_latch.sv
// ---------------------------------------------------------------------------
// tb_demux_1x2_latch
// Directed steps followed by random traffic, each cycle compared against a
// behavioural model of two holding slots (full flag, data, transfer count).
// ---------------------------------------------------------------------------
module tb_demux_1x2_latch;

  localparam int W = 8;
  localparam int C = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] inputValue;
  logic         select;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] outputValue1, outputValue2;
  logic         valid1, valid2;
  logic         ack1, ack2;
  logic [C-1:0] count1, count2;
`ifdef DEMUX_OVERWRITE_EN
  logic         overrun;
`endif

  demux_1x2_latch #(.WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .inputValue   (inputValue),
    .select       (select),
    .inValid      (inValid),
    .inReady      (inReady),
    .outputValue1 (outputValue1),
    .outputValue2 (outputValue2),
    .valid1       (valid1),
    .valid2       (valid2),
    .ack1         (ack1),
    .ack2         (ack2),
    .count1       (count1),
    .count2       (count2)
`ifdef DEMUX_OVERWRITE_EN
    ,
    .overrun      (overrun)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot index 0 is slot 1, index 1 is slot 2.
  bit m_full[2];
  int m_data[2];
  int m_cnt[2];
  bit m_overrun;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit sel, input bit a1, input bit a2);
`ifdef DEMUX_OVERWRITE_EN
    return 1'b1;
`else
    return sel ? (!m_full[1] || a2) : (!m_full[0] || a1);
`endif
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out1"},   32'(outputValue1), 32'(m_data[0]));
    chk({tag, ".out2"},   32'(outputValue2), 32'(m_data[1]));
    chk({tag, ".valid1"}, 32'(valid1),       32'(m_full[0]));
    chk({tag, ".valid2"}, 32'(valid2),       32'(m_full[1]));
    chk({tag, ".count1"}, 32'(count1),       32'(m_cnt[0]));
    chk({tag, ".count2"}, 32'(count2),       32'(m_cnt[1]));
`ifdef DEMUX_OVERWRITE_EN
    chk({tag, ".overrun"}, 32'(overrun),     32'(m_overrun));
`endif
  endtask

  // Driver: called just after a falling edge. Checks inReady before the
  // rising edge, advances the model on the edge, checks outputs after it.
  task automatic step(input string tag, input bit v, input bit sel,
                      input logic [W-1:0] d, input bit a1, input bit a2);
    bit rdy;
    int s;
    inValid    = v;
    select     = sel;
    inputValue = d;
    ack1       = a1;
    ack2       = a2;
    #1;
    rdy = model_ready(sel, a1, a2);
    chk({tag, ".inReady"}, 32'(inReady), 32'(rdy));
    @(posedge clk);
    s = sel ? 1 : 0;
    if (v && rdy) begin
      if (m_full[s] && !(sel ? a2 : a1)) m_overrun = 1'b1;
      m_full[s] = 1'b1;
      m_data[s] = int'(d);
      m_cnt[s]  = (m_cnt[s] + 1) % (1 << C);
    end else if (sel ? a2 : a1) begin
      m_full[s] = 1'b0;
    end
    // The slot not addressed by this write only reacts to its own ack.
    if (sel ? a1 : a2) m_full[1 - s] = 1'b0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic reset_dut(input string tag, input int cycles, input bit v, input bit a1);
    reset      = 1'b1;
    inValid    = v;
    ack1       = a1;
    ack2       = 1'b0;
    select     = 1'b0;
    inputValue = W'($urandom_range(0, 255));
    repeat (cycles) @(posedge clk);
    m_full    = '{0, 0};
    m_data    = '{0, 0};
    m_cnt     = '{0, 0};
    m_overrun = 1'b0;
    @(negedge clk);
    check_outputs(tag);
    chk({tag, ".inReady"}, 32'(inReady), 32'd1);
    reset   = 1'b0;
    inValid = 1'b0;
    ack1    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; select = 1'b0; inputValue = '0;
    ack1 = 1'b0; ack2 = 1'b0;
    @(negedge clk);

    // Reset with traffic present.
    reset_dut("reset", 2, 1'b1, 1'b1);
    chk("reset.out1_zero", 32'(outputValue1), 32'h00);
    chk("reset.count2_zero", 32'(count2), 32'h00);

    // Steering.
    step("steer_a5", 1, 0, 8'hA5, 0, 0);
    chk("steer.out1_a5", 32'(outputValue1), 32'hA5);
    chk("steer.valid1", 32'(valid1), 32'd1);
    step("steer_3c", 1, 1, 8'h3C, 0, 0);
    chk("steer.out2_3c", 32'(outputValue2), 32'h3C);
    chk("steer.counts", {count1, count2}, {8'd1, 8'd1});

    // Same-cycle ack + write into a FULL slot 1, then drain slot 2.
    step("ackwr_11", 1, 0, 8'h11, 1, 0);
    chk("ackwr.out1_11", 32'(outputValue1), 32'h11);
    step("drain2", 0, 0, 8'h00, 0, 1);
    chk("drain2.valid2", 32'(valid2), 32'd0);

    // Back-pressure on FULL slot 1 without ack.
    step("bp_22", 1, 0, 8'h22, 0, 0);
`ifndef DEMUX_OVERWRITE_EN
    chk("bp.out1_held", 32'(outputValue1), 32'h11);
    chk("bp.count1_held", 32'(count1), 32'd2);
`else
    chk("ovw.out1_22", 32'(outputValue1), 32'h22);
    chk("ovw.overrun", 32'(overrun), 32'd1);
`endif
    step("bp_slot2", 1, 1, 8'h55, 0, 0);
    chk("bp.out2_55", 32'(outputValue2), 32'h55);
    step("ackwr_22", 1, 0, 8'h22, 1, 0);
    chk("ackwr2.out1_22", 32'(outputValue1), 32'h22);
    chk("ackwr2.valid1", 32'(valid1), 32'd1);

    // Counter wrap on slot 2 with ack2 held.
    reset_dut("reset_wrap", 1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      step("wrap", 1, 1, W'($urandom_range(0, 255)), 0, 1);
    chk("wrap.count2_zero", 32'(count2), 32'h00);
    step("wrap_drain", 0, 0, 8'h00, 0, 1);
    step("spurious_ack2", 0, 0, 8'h00, 0, 1);
    chk("spurious.valid2", 32'(valid2), 32'd0);

`ifdef DEMUX_OVERWRITE_EN
    // Overwrite without ack; overrun stays set until reset.
    step("ovw_11", 1, 0, 8'h11, 0, 0);
    step("ovw_99", 1, 0, 8'h99, 0, 0);
    chk("ovw.out1_99", 32'(outputValue1), 32'h99);
    chk("ovw.overrun_set", 32'(overrun), 32'd1);
    step("ovw_idle", 0, 0, 8'h00, 1, 1);
    chk("ovw.overrun_sticky", 32'(overrun), 32'd1);
`endif

    // Reset mid-transfer.
    step("pre_mid", 1, 0, 8'h7E, 0, 0);
    reset_dut("reset_mid", 1, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           W'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
